// File: rtl/video_timing_gen.sv
// Free-running raster timing generator (pixel clock domain).
// Produces pixel coordinates, hsync/vsync, active-draw, a new-frame strobe and a frame counter.
// All outputs are registered from one next-pixel pointer, so they always describe the same pixel.
// H_TOTAL must not exceed 2048 and V_TOTAL must not exceed 1024 (fixed 11/10-bit counters).
// Every porch and sync width must be at least 1.
module video_timing_gen #(
    parameter int unsigned H_ACTIVE = 1280,
    parameter int unsigned H_FP     = 110,
    parameter int unsigned H_SYNC   = 40,
    parameter int unsigned H_BP     = 220,
    parameter int unsigned V_ACTIVE = 720,
    parameter int unsigned V_FP     = 5,
    parameter int unsigned V_SYNC   = 5,
    parameter int unsigned V_BP     = 20,
    parameter int unsigned SYNC_POL = 1,
    parameter int unsigned FC_WIDTH = 6
) (
    input  logic                clk_in,
    input  logic                rst_in,
    output logic [10:0]         hcount_out,
    output logic [9:0]          vcount_out,
    output logic                hsync_out,
    output logic                vsync_out,
    output logic                active_draw_out,
    output logic                new_frame_out,
    output logic [FC_WIDTH-1:0] frame_count_out
);

    localparam int unsigned HW           = 11;
    localparam int unsigned VW           = 10;
    localparam int unsigned H_TOTAL      = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL      = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned H_SYNC_START = H_ACTIVE + H_FP;
    localparam int unsigned H_SYNC_END   = H_SYNC_START + H_SYNC;
    localparam int unsigned V_SYNC_START = V_ACTIVE + V_FP;
    localparam int unsigned V_SYNC_END   = V_SYNC_START + V_SYNC;
    localparam logic        SYNC_ON      = (SYNC_POL != 0);
    localparam logic        SYNC_OFF     = ~SYNC_ON;

    // Pointer to the pixel whose timing is loaded into the outputs on the next edge
    logic [HW-1:0] ptr_h;
    logic [VW-1:0] ptr_v;
    logic [HW-1:0] ptr_h_nxt;
    logic [VW-1:0] ptr_v_nxt;
    logic          active_c;
    logic          hsync_c;
    logic          vsync_c;
    logic          frame_c;

    // Advance the pointer in raster order and decode its timing regions
    always_comb begin
        ptr_h_nxt = ptr_h + HW'(1);
        ptr_v_nxt = ptr_v;
        if (ptr_h == HW'(H_TOTAL - 1)) begin
            ptr_h_nxt = '0;
            if (ptr_v == VW'(V_TOTAL - 1)) begin
                ptr_v_nxt = '0;
            end else begin
                ptr_v_nxt = ptr_v + VW'(1);
            end
        end

        active_c = (ptr_h < HW'(H_ACTIVE)) && (ptr_v < VW'(V_ACTIVE));
        hsync_c  = (ptr_h >= HW'(H_SYNC_START)) && (ptr_h < HW'(H_SYNC_END));
        vsync_c  = (ptr_v >= VW'(V_SYNC_START)) && (ptr_v < VW'(V_SYNC_END));
        frame_c  = (ptr_h == HW'(H_ACTIVE)) && (ptr_v == VW'(V_ACTIVE));
    end

    // Register the decoded pixel; reset aborts the raster and parks the pointer at (0,0)
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            ptr_h           <= '0;
            ptr_v           <= '0;
            hcount_out      <= '0;
            vcount_out      <= '0;
            hsync_out       <= SYNC_OFF;
            vsync_out       <= SYNC_OFF;
            active_draw_out <= 1'b0;
            new_frame_out   <= 1'b0;
            frame_count_out <= '0;
        end else begin
            ptr_h           <= ptr_h_nxt;
            ptr_v           <= ptr_v_nxt;
            hcount_out      <= ptr_h;
            vcount_out      <= ptr_v;
            hsync_out       <= hsync_c ? SYNC_ON : SYNC_OFF;
            vsync_out       <= vsync_c ? SYNC_ON : SYNC_OFF;
            active_draw_out <= active_c;
            new_frame_out   <= frame_c;
            if (frame_c) begin
                frame_count_out <= frame_count_out + FC_WIDTH'(1);
            end
        end
    end

endmodule
